// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through all 8 input vectors and assembles its 8-bit rule code.
// Optional stability check: define TRUTH_TABLE_SWEEPER_STABILITY_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for start, results held
// APPLY   | vector driven, settle counter running
// CAPTURE | gate_out sampled into rule_code at the closing edge
// FINISH  | one-cycle done pulse, match registered
module truth_table_sweeper #(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] EXPECTED_RULE = 8'h45
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       gate_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] rule_code,
  output logic       match,
  output logic       unstable
);

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, FINISH} state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] idx;
  logic [7:0] cnt;
  logic       unstable_now;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   if (cnt == 8'd0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (idx == 3'd7) ? FINISH : APPLY;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= 3'd0;
      cnt       <= 8'd0;
      rule_code <= 8'h00;
      match     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= 3'd0;
            cnt       <= RELOAD;
            rule_code <= 8'h00;
            match     <= 1'b0;
          end
        end
        APPLY: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
        end
        CAPTURE: begin
          rule_code[3'd7 - idx] <= gate_out;
          if (idx != 3'd7) begin
            idx <= idx + 3'd1;
            cnt <= RELOAD;
          end
        end
        FINISH: begin
          match <= (rule_code == EXPECTED_RULE) && !unstable_now;
          idx   <= 3'd0;
        end
        default: ;
      endcase
    end
  end

`ifdef TRUTH_TABLE_SWEEPER_STABILITY_CHECK_EN
  logic settle_sample;

  // Compare the last settled sample with the capture sample of the same vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_sample <= 1'b0;
      unstable      <= 1'b0;
    end else begin
      if (state == IDLE && start) unstable <= 1'b0;
      if (state == APPLY && cnt == 8'd0) settle_sample <= gate_out;
      if (state == CAPTURE && gate_out != settle_sample) unstable <= 1'b1;
    end
  end

  assign unstable_now = unstable;
`else
  assign unstable     = 1'b0;
  assign unstable_now = 1'b0;
`endif

  assign {in1, in2, in3} = idx;
  assign busy = (state == APPLY) || (state == CAPTURE);
  assign done = (state == FINISH);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: directed and random gate rules vs. a truth-table model.
module tb_truth_table_sweeper;

  localparam int S = 4;
  localparam int L = 8 * (S + 1);
  localparam logic [7:0] EXP_RULE = 8'h45;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in1, in2, in3;
  logic       gate_out;
  logic       busy, done, match, unstable;
  logic [7:0] rule_code;

  logic [7:0] gate_rule = 8'h00;
  logic       inv = 1'b0;
  logic       glitch = 1'b0;
  logic [2:0] gate_x;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Gate under test: gate_rule is a rule code, so vector x selects bit 7-x.
  assign gate_x   = {in1, in2, in3} ^ {3{inv}};
  assign gate_out = gate_rule[3'd7 - gate_x] ^ glitch;

  truth_table_sweeper #(.SETTLE_CYCLES(S), .EXPECTED_RULE(EXP_RULE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in1(in1), .in2(in2), .in3(in3), .gate_out(gate_out),
    .busy(busy), .done(done), .rule_code(rule_code),
    .match(match), .unstable(unstable)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // restart_at / reset_at: cycle offset after the accepted start edge (0 = unused).
  task automatic run_sweep(input logic [7:0] r, input logic iv, input int glitch_vec,
                           input int restart_at, input int reset_at);
    logic [7:0] exp_code;
    logic       exp_unst;
    logic       exp_match;
    int         vec, pos, x, done_seen;
    gate_rule = r;
    inv       = iv;
    glitch    = 1'b0;
    exp_code  = 8'h00;
    for (int v = 0; v < 8; v++) begin
      x = iv ? 7 - v : v;
      exp_code[7 - v] = r[7 - x] ^ (v == glitch_vec);
    end
    exp_unst = 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_STABILITY_CHECK_EN
    if (glitch_vec >= 0) exp_unst = 1'b1;
`endif
    exp_match = (exp_code == EXP_RULE) && !exp_unst;

    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      start  = 1'b0;
      glitch = 1'b0;
      check("busy", busy, k <= L);
      check("done", done, k == L + 1);
      if (k <= L) begin
        vec = (k - 1) / (S + 1);
        pos = (k - 1) % (S + 1);
        check("vector", {in1, in2, in3}, vec);
        if (vec == glitch_vec && pos == S) glitch = 1'b1;
      end
      if (k == restart_at) start = 1'b1;
      if (k == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_inputs", {in1, in2, in3}, 0);
        check("rst_rule", rule_code, 0);
        check("rst_match", match, 0);
        done_seen = 0;
        repeat (L + 5) begin
          @(negedge clk);
          if (done) done_seen++;
        end
        check("rst_no_done", done_seen, 0);
        return;
      end
      if (k == L + 2) begin
        check("rule_code", rule_code, exp_code);
        check("match", match, exp_match);
        check("unstable", unstable, exp_unst);
        check("idle_inputs", {in1, in2, in3}, 0);
      end
    end
    // results must hold through idle
    repeat (3) @(negedge clk);
    check("hold_rule", rule_code, exp_code);
    check("hold_match", match, exp_match);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rule", rule_code, 0);
    check("reset_match", match, 0);
    check("reset_unstable", unstable, 0);
    check("reset_inputs", {in1, in2, in3}, 0);
    reset = 1'b0;
    @(negedge clk);

    run_sweep(8'h45, 1'b0, -1, 0, 0);
    run_sweep(8'h00, 1'b0, -1, 0, 0);
    run_sweep(8'hFF, 1'b0, -1, 0, 0);
    run_sweep(8'h45, 1'b1, -1, 0, 0);
    run_sweep(8'h45, 1'b0, -1, 3 * (S + 1) + 2, 0);
    run_sweep(8'h45, 1'b0, -1, L + 1, 0);
    run_sweep(8'h45, 1'b0, -1, 0, 5 * (S + 1) + 2);
    run_sweep(8'h45, 1'b0, -1, 0, 0);
    run_sweep(8'h45, 1'b0, 2, 0, 0);
    run_sweep(8'h45, 1'b0, -1, 0, 0);

    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_sweep(8'($urandom), 1'($urandom_range(0, 1)), -1, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Characterisation harness for 3-input combinational logic gate blocks.
- Upstream of the gate, it drives in1/in2/in3 through all 8 vectors. Downstream of the gate, it samples out after a settle window.
- Assembles the observed 8-bit rule code and compares it against the expected code, giving self-checking sweeps of gate netlists.

Parameters:
SETTLE_CYCLES, 4, cycles each vector is held before capture; legal range 1..255
EXPECTED_RULE, 8'h45, expected rule code for the match flag

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a sweep; honoured only in IDLE
in1  output  1  gate input MSB; equals vector index bit 2
in2  output  1  gate input; equals vector index bit 1
in3  output  1  gate input LSB; equals vector index bit 0
gate_out  input  1  output of the gate under test
busy  output  1  high while the sweep is in progress
done  output  1  one-cycle pulse when a sweep completes
rule_code  output  8  captured rule code
match  output  1  rule_code == EXPECTED_RULE; valid after done
unstable  output  1  stability error flag (see Optional Feature)

Behaviour:
- Reset values (at the clock edge with reset=1): state IDLE, vector index 0, {in1,in2,in3}=3'b000, busy=0, done=0, rule_code=8'h00, match=0, unstable=0.
- Reset asserted mid-sweep aborts the sweep immediately. Partial results are discarded.
- State machine:
  - IDLE: when start=1, go to APPLY. Index=0, settle counter loads SETTLE_CYCLES-1, rule_code clears to 0, match and unstable clear to 0.
  - APPLY: counter decrements each cycle. When the counter is 0, go to CAPTURE.
  - CAPTURE: at the edge ending this cycle, rule_code[7-index] <= gate_out.
    - If index==7, go to FINISH.
    - Otherwise index+1, counter reloads SETTLE_CYCLES-1, go to APPLY.
  - FINISH: done=1 for exactly this cycle. match registered from the final rule_code value, including the bit captured at the CAPTURE->FINISH edge. Go to IDLE.
- Bit ordering: vector index {in1,in2,in3}=i maps to rule_code bit 7-i. Vector 000 is the MSB and 111 is the LSB.
- {in1,in2,in3} is driven from registered index every cycle in APPLY and CAPTURE. The value changes only at the CAPTURE->APPLY edge. It returns to 000 on entry to IDLE.
- Each vector is presented for SETTLE_CYCLES+1 cycles. busy=1 in APPLY and CAPTURE only.
- Timing with start sampled at edge E:
  - busy is high for cycles E+1 .. E+8*(SETTLE_CYCLES+1).
  - done is high in the cycle after that.
- start in APPLY, CAPTURE or FINISH is ignored. It is not queued.
- rule_code, match and unstable hold their values in IDLE until the next accepted start.
- Index counter is 3 bits. There is no wrap past 7, because FINISH is always taken at 7.

Optional Feature:
- Macro: TRUTH_TABLE_SWEEPER_STABILITY_CHECK_EN
- Defined:
  - gate_out is also sampled at the edge ending the last APPLY cycle of each vector (counter==0).
  - If that sample differs from the CAPTURE sample, unstable is set.
  - unstable is sticky until the next accepted start or reset.
  - match is forced to 0 in FINISH when unstable=1.
- Not defined: the unstable port exists but is tied to 0, and match depends only on the rule_code comparison.

Test Plan:
- Gate model: rule 0x45 (out=1 for vectors 001,101,111), SETTLE_CYCLES=4. Pulse start at edge E -> busy high E+1..E+40, done pulse at E+41, rule_code=8'h45, match=1.
- Gate model: constant 0 -> rule_code=8'h00, match=0. Constant 1 -> rule_code=8'hFF, match=0.
- Gate model: inputs inverted. Rule 0x45 on ~{in1,in2,in3} gives rule_code=8'hA2, match=0. Verifies bit ordering.
- start re-pulsed while busy at vector 3 -> ignored; sweep completes once with unchanged timing. start in FINISH cycle -> ignored, stays IDLE.
- reset asserted during vector 5 APPLY -> next cycle busy=0, inputs=000, rule_code=0, no done. Fresh start gives a correct full sweep.
- With TRUTH_TABLE_SWEEPER_STABILITY_CHECK_EN: gate model toggles out only during the CAPTURE cycle of vector 2 -> unstable=1 at done, match=0. Next clean sweep clears unstable and gives match=1.
